// File: rtl/power_load_gen.sv
// Burst-mode switching-activity generator: drives LFSR operands into a multiplier array in
// RUN/QUIET bursts. Define POWER_LOAD_GEN_STATS_EN to enable the saturating BURST_COUNT counter.
module power_load_gen #(
   parameter logic [15:0] ON_CYCLES  = 16'd128,
   parameter logic [15:0] OFF_CYCLES = 16'd128,
   parameter logic [31:0] A_SEED     = 32'h0000_0001,
   parameter logic [31:0] B_SEED     = 32'hACE1_2468
) (
   input  logic        ICE_CLK,
   input  logic        RST,
   input  logic        EN,
   output logic [31:0] A,
   output logic [31:0] B,
   output logic        ACTIVE,
   output logic        BURST_DONE,
   output logic [15:0] BURST_COUNT
);

   typedef enum logic [1:0] {StIdle, StRun, StQuiet} state_e;

   state_e      state_q;
   logic [15:0] cnt_q;
   logic [31:0] lfsr_a_q, lfsr_b_q;
   logic [31:0] lfsr_a_d, lfsr_b_d;
   logic [31:0] a_q, b_q;
   logic        active_q;
   logic        done_q;
   logic        burst_end;

   function automatic logic [31:0] lfsr_next(input logic [31:0] x);
      return {x[30:0], x[31] ^ x[21] ^ x[1] ^ x[0]};
   endfunction

   assign lfsr_a_d  = lfsr_next(lfsr_a_q);
   assign lfsr_b_d  = lfsr_next(lfsr_b_q);
   assign burst_end = (state_q == StRun) && EN && (cnt_q == ON_CYCLES - 16'd1);

   // The LFSRs advance only on the edges that present a value, so each operand pair is unique.
   always_ff @(posedge ICE_CLK or posedge RST) begin
      if (RST) begin
         state_q  <= StIdle;
         cnt_q    <= 16'd0;
         lfsr_a_q <= A_SEED;
         lfsr_b_q <= B_SEED;
         a_q      <= 32'd0;
         b_q      <= 32'd0;
         active_q <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               done_q <= 1'b0;
               if (EN) begin
                  state_q  <= StRun;
                  cnt_q    <= 16'd0;
                  a_q      <= lfsr_a_q;
                  b_q      <= lfsr_b_q;
                  lfsr_a_q <= lfsr_a_d;
                  lfsr_b_q <= lfsr_b_d;
                  active_q <= 1'b1;
               end
            end
            StRun: begin
               if (!EN) begin
                  state_q  <= StIdle;
                  cnt_q    <= 16'd0;
                  a_q      <= 32'd0;
                  b_q      <= 32'd0;
                  active_q <= 1'b0;
                  done_q   <= 1'b0;
               end else if (cnt_q == ON_CYCLES - 16'd1) begin
                  state_q  <= StQuiet;
                  cnt_q    <= 16'd0;
                  a_q      <= 32'd0;
                  b_q      <= 32'd0;
                  active_q <= 1'b0;
                  done_q   <= 1'b1;
               end else begin
                  cnt_q    <= cnt_q + 16'd1;
                  a_q      <= lfsr_a_q;
                  b_q      <= lfsr_b_q;
                  lfsr_a_q <= lfsr_a_d;
                  lfsr_b_q <= lfsr_b_d;
               end
            end
            StQuiet: begin
               done_q <= 1'b0;
               if (cnt_q == OFF_CYCLES - 16'd1) begin
                  cnt_q <= 16'd0;
                  if (EN) begin
                     state_q  <= StRun;
                     a_q      <= lfsr_a_q;
                     b_q      <= lfsr_b_q;
                     lfsr_a_q <= lfsr_a_d;
                     lfsr_b_q <= lfsr_b_d;
                     active_q <= 1'b1;
                  end else begin
                     state_q <= StIdle;
                  end
               end else begin
                  cnt_q <= cnt_q + 16'd1;
               end
            end
            default: begin
               state_q  <= StIdle;
               cnt_q    <= 16'd0;
               a_q      <= 32'd0;
               b_q      <= 32'd0;
               active_q <= 1'b0;
               done_q   <= 1'b0;
            end
         endcase
      end
   end

`ifdef POWER_LOAD_GEN_STATS_EN
   logic [15:0] burst_count_q;

   always_ff @(posedge ICE_CLK or posedge RST) begin
      if (RST) begin
         burst_count_q <= 16'd0;
      end else if (burst_end && (burst_count_q != 16'hFFFF)) begin
         burst_count_q <= burst_count_q + 16'd1;
      end
   end

   assign BURST_COUNT = burst_count_q;
`else
   logic unused_burst_end;
   assign unused_burst_end = burst_end;
   assign BURST_COUNT      = 16'h0000;
`endif

   assign A          = a_q;
   assign B          = b_q;
   assign ACTIVE     = active_q;
   assign BURST_DONE = done_q;

endmodule

// File: tb/tb_power_load_gen.sv
// Self-checking bench for power_load_gen: directed scenarios plus randomized EN/RST traffic
// compared against a burst-level reference model.
module tb_power_load_gen;

`ifdef POWER_LOAD_GEN_STATS_EN
   localparam bit Stats = 1'b1;
`else
   localparam bit Stats = 1'b0;
`endif
   localparam int OnC  = 4;
   localparam int OffC = 2;

   logic        ICE_CLK;
   logic        RST;
   logic        EN;
   logic [31:0] A, B, A2, B2;
   logic        ACTIVE, BURST_DONE, ACTIVE2, BURST_DONE2;
   logic [15:0] BURST_COUNT, BURST_COUNT2;

   int errors = 0;
   int checks = 0;

   power_load_gen #(
      .ON_CYCLES (16'd4),
      .OFF_CYCLES(16'd2),
      .A_SEED    (32'h0000_0001),
      .B_SEED    (32'hACE1_2468)
   ) dut (
      .ICE_CLK    (ICE_CLK),
      .RST        (RST),
      .EN         (EN),
      .A          (A),
      .B          (B),
      .ACTIVE     (ACTIVE),
      .BURST_DONE (BURST_DONE),
      .BURST_COUNT(BURST_COUNT)
   );

   power_load_gen #(
      .ON_CYCLES (16'd1),
      .OFF_CYCLES(16'd1)
   ) dut2 (
      .ICE_CLK    (ICE_CLK),
      .RST        (RST),
      .EN         (EN),
      .A          (A2),
      .B          (B2),
      .ACTIVE     (ACTIVE2),
      .BURST_DONE (BURST_DONE2),
      .BURST_COUNT(BURST_COUNT2)
   );

   initial begin
      ICE_CLK = 1'b0;
      forever #5 ICE_CLK = ~ICE_CLK;
   end

   // Reference model: phase 0=idle, 1=burst on, 2=gap; m_left counts cycles left in the phase.
   int          m_phase;
   int          m_left;
   logic [31:0] m_la, m_lb, m_a, m_b;
   logic        m_act, m_done;
   int          m_bc;

   function automatic logic [31:0] ref_next(input logic [31:0] x);
      logic [31:0] fb;
      fb = (x >> 31) ^ (x >> 21) ^ (x >> 1) ^ x;
      return (x << 1) | (fb & 32'd1);
   endfunction

   function automatic logic [15:0] exp_bc(input int n);
      if (!Stats) return 16'h0000;
      return (n > 65535) ? 16'hFFFF : n[15:0];
   endfunction

   task automatic model_reset();
      m_phase = 0; m_left = 0;
      m_la = 32'h0000_0001; m_lb = 32'hACE1_2468;
      m_a = 0; m_b = 0; m_act = 0; m_done = 0; m_bc = 0;
   endtask

   task automatic model_present();
      m_phase = 1; m_left = OnC;
      m_a = m_la; m_b = m_lb;
      m_la = ref_next(m_la); m_lb = ref_next(m_lb);
      m_act = 1; m_done = 0;
   endtask

   task automatic model_step(input bit en);
      case (m_phase)
         0: begin
            m_done = 0;
            if (en) model_present();
         end
         1: begin
            if (!en) begin
               m_phase = 0; m_a = 0; m_b = 0; m_act = 0; m_done = 0;
            end else begin
               m_left = m_left - 1;
               if (m_left == 0) begin
                  m_phase = 2; m_left = OffC;
                  m_a = 0; m_b = 0; m_act = 0; m_done = 1;
                  m_bc = m_bc + 1;
               end else begin
                  m_a = m_la; m_b = m_lb;
                  m_la = ref_next(m_la); m_lb = ref_next(m_lb);
               end
            end
         end
         default: begin
            m_done = 0;
            m_left = m_left - 1;
            if (m_left == 0) begin
               if (en) model_present();
               else m_phase = 0;
            end
         end
      endcase
   endtask

   // Advance one clock with EN=en; returns at the following negedge.
   task automatic step(input bit en);
      EN = en;
      model_step(en);
      @(negedge ICE_CLK);
   endtask

   task automatic do_reset();
      RST = 1'b1;
      model_reset();
      @(negedge ICE_CLK);
      RST = 1'b0;
   endtask

   task automatic test_reset();
      EN = 1'b0;
      RST = 1'b1;
      model_reset();
      @(negedge ICE_CLK);
      checks += 5;
      if (A !== 32'd0) begin errors++; $display("FAIL reset_a got=%h exp=0", A); end
      if (B !== 32'd0) begin errors++; $display("FAIL reset_b got=%h exp=0", B); end
      if (ACTIVE !== 1'b0) begin errors++; $display("FAIL reset_active got=%b exp=0", ACTIVE); end
      if (BURST_DONE !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", BURST_DONE); end
      if (BURST_COUNT !== 16'd0) begin
         errors++; $display("FAIL reset_count got=%h exp=0", BURST_COUNT);
      end
      RST = 1'b0;
      step(1'b0);
      checks++;
      if (ACTIVE !== 1'b0 || A !== 32'd0) begin
         errors++; $display("FAIL idle_hold got_active=%b got_a=%h exp=0/0", ACTIVE, A);
      end
   endtask

   task automatic test_first_burst();
      logic [31:0] exp_a[4];
      logic [31:0] exp_b;
      exp_a[0] = 32'h1; exp_a[1] = 32'h3; exp_a[2] = 32'h6; exp_a[3] = 32'hD;
      exp_b = 32'hACE1_2468;
      do_reset();
      for (int i = 0; i < 4; i++) begin
         step(1'b1);
         checks += 3;
         if (A !== exp_a[i]) begin errors++; $display("FAIL run_a[%0d] got=%h exp=%h", i, A, exp_a[i]); end
         if (B !== exp_b) begin errors++; $display("FAIL run_b[%0d] got=%h exp=%h", i, B, exp_b); end
         if (ACTIVE !== 1'b1 || BURST_DONE !== 1'b0) begin
            errors++; $display("FAIL run_flags[%0d] got=%b%b exp=10", i, ACTIVE, BURST_DONE);
         end
         exp_b = ref_next(exp_b);
      end
      for (int i = 0; i < 2; i++) begin
         step(1'b1);
         checks += 2;
         if (A !== 32'd0 || B !== 32'd0 || ACTIVE !== 1'b0) begin
            errors++; $display("FAIL quiet[%0d] got_a=%h got_b=%h got_act=%b exp=0", i, A, B, ACTIVE);
         end
         if (BURST_DONE !== (i == 0)) begin
            errors++; $display("FAIL quiet_done[%0d] got=%b exp=%b", i, BURST_DONE, i == 0);
         end
      end
      step(1'b1);
      checks++;
      if (A !== 32'h1B || ACTIVE !== 1'b1) begin
         errors++; $display("FAIL second_burst_a got=%h act=%b exp=1b/1", A, ACTIVE);
      end
   endtask

   task automatic test_burst_count();
      do_reset();
      for (int b = 1; b <= 3; b++) begin
         for (int i = 0; i < OnC; i++) step(1'b1);
         step(1'b1);
         checks += 2;
         if (BURST_DONE !== 1'b1) begin errors++; $display("FAIL count_done[%0d] got=%b exp=1", b, BURST_DONE); end
         if (BURST_COUNT !== exp_bc(b)) begin
            errors++; $display("FAIL burst_count[%0d] got=%h exp=%h", b, BURST_COUNT, exp_bc(b));
         end
         step(1'b1);
      end
   endtask

   task automatic test_abort_run();
      do_reset();
      step(1'b1);
      step(1'b1);
      step(1'b0);
      checks += 2;
      if (A !== 32'd0 || B !== 32'd0 || ACTIVE !== 1'b0) begin
         errors++; $display("FAIL abort_out got_a=%h got_b=%h got_act=%b exp=0", A, B, ACTIVE);
      end
      if (BURST_DONE !== 1'b0 || BURST_COUNT !== 16'd0) begin
         errors++; $display("FAIL abort_done got=%b cnt=%h exp=0/0", BURST_DONE, BURST_COUNT);
      end
      step(1'b0);
      step(1'b1);
      checks++;
      if (A !== 32'h6 || ACTIVE !== 1'b1) begin
         errors++; $display("FAIL abort_resume got=%h act=%b exp=6/1", A, ACTIVE);
      end
   endtask

   task automatic test_quiet_en_drop();
      do_reset();
      for (int i = 0; i < OnC + 1; i++) step(1'b1);
      step(1'b0);
      checks++;
      if (A !== 32'd0 || ACTIVE !== 1'b0 || BURST_DONE !== 1'b0) begin
         errors++; $display("FAIL quiet_drop_q2 got_a=%h act=%b done=%b exp=0", A, ACTIVE, BURST_DONE);
      end
      step(1'b0);
      step(1'b0);
      checks++;
      if (A !== 32'd0 || B !== 32'd0 || ACTIVE !== 1'b0) begin
         errors++; $display("FAIL quiet_drop_idle got_a=%h got_b=%h act=%b exp=0", A, B, ACTIVE);
      end
      step(1'b1);
      checks++;
      if (A !== 32'h1B) begin errors++; $display("FAIL quiet_drop_resume got=%h exp=1b", A); end
   endtask

   task automatic test_reset_mid_run();
      do_reset();
      for (int i = 0; i < 3; i++) step(1'b1);
      RST = 1'b1;
      model_reset();
      #1;
      checks++;
      if (A !== 32'd0 || B !== 32'd0 || ACTIVE !== 1'b0 || BURST_DONE !== 1'b0) begin
         errors++; $display("FAIL async_reset got_a=%h got_b=%h act=%b done=%b exp=0", A, B, ACTIVE,
                            BURST_DONE);
      end
      @(negedge ICE_CLK);
      RST = 1'b0;
      step(1'b1);
      checks += 2;
      if (A !== 32'h1 || B !== 32'hACE1_2468) begin
         errors++; $display("FAIL reset_reseed got_a=%h got_b=%h exp=1/ace12468", A, B);
      end
      if (BURST_COUNT !== 16'd0) begin errors++; $display("FAIL reset_count2 got=%h exp=0", BURST_COUNT); end
   endtask

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 199) == 0) begin
            RST = 1'b1;
            model_reset();
            @(negedge ICE_CLK);
            RST = 1'b0;
         end
         step($urandom_range(0, 11) != 0);
         checks++;
         if (A !== m_a || B !== m_b || ACTIVE !== m_act || BURST_DONE !== m_done ||
             BURST_COUNT !== exp_bc(m_bc)) begin
            errors++;
            $display("FAIL random[%0d] got a=%h b=%h act=%b done=%b cnt=%h exp a=%h b=%h act=%b done=%b cnt=%h",
                     i, A, B, ACTIVE, BURST_DONE, BURST_COUNT, m_a, m_b, m_act, m_done, exp_bc(m_bc));
         end
      end
   endtask

   task automatic test_alternate();
      do_reset();
      for (int i = 0; i < 200; i++) begin
         step(1'b1);
         checks++;
         if (ACTIVE2 !== (i % 2 == 0) || BURST_DONE2 !== (i % 2 == 1) ||
             BURST_COUNT2 !== exp_bc((i + 1) / 2)) begin
            errors++;
            $display("FAIL alternate[%0d] got act=%b done=%b cnt=%h exp act=%b done=%b cnt=%h", i, ACTIVE2,
                     BURST_DONE2, BURST_COUNT2, i % 2 == 0, i % 2 == 1, exp_bc((i + 1) / 2));
         end
      end
`ifdef POWER_LOAD_GEN_STATS_EN
      force dut2.burst_count_q = 16'hFFFD;
      #1;
      release dut2.burst_count_q;
      for (int i = 0; i < 6; i++) begin
         step(1'b1);
         if (i % 2 == 1) begin
            checks++;
            if (BURST_COUNT2 !== ((i == 1) ? 16'hFFFE : 16'hFFFF)) begin
               errors++; $display("FAIL saturate[%0d] got=%h exp=%h", i, BURST_COUNT2,
                                  (i == 1) ? 16'hFFFE : 16'hFFFF);
            end
         end
      end
`endif
   endtask

   initial begin
      RST = 1'b1;
      EN  = 1'b0;
      model_reset();
      @(negedge ICE_CLK);
      test_reset();
      test_first_burst();
      test_burst_count();
      test_abort_run();
      test_quiet_en_drop();
      test_reset_mid_run();
      test_random();
      test_alternate();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
